cpu_run_sequencer: RTL and testbench
====================================

# cpu_run_sequencer

Synthesisable run controller that sits between the top-level board/bench clock and reset and the `CPU` core. It sequences a multi-cycle CPU reset, enables the core for a run, and ends the run on a halt instruction, a PC hang, or a cycle budget. It reports cycle counts and the termination cause, and supports aborting a run and starting new ones. It generalises the fixed reset-then-run-then-reset-again sequencing used in CPU bring-up into a parametrised, repeatable, self-terminating block.

## Interface

Parameters:
- `RST_CYCLES`, default 2: number of cycles `CPU_RST` is held high per run (≥1).
- `MAX_CYCLES`, default 1000: RUN-cycle budget before timeout (≥2).
- `STALL_LIMIT`, default 16: consecutive unchanged-PC cycles declared a hang (≥2).
- `CNT_W`, default 32: width of `CYCLES`.
- `PC_W`, default 32: PC width.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `START` in 1: request a run; sampled in IDLE and DONE only.
- `ABORT` in 1: force a restart while in RUN.
- `PC_IN` in PC_W: current IF-stage PC from the core.
- `INSTR_IN` in 32: instruction fetched at `PC_IN`.
- `INSTR_VALID` in 1: `INSTR_IN` is a real (non-bubble) fetch.
- `CPU_RST` out 1: reset to the core.
- `CPU_EN` out 1: clock-enable/run permission to the core.
- `DONE` out 1: run finished; held high until the next START.
- `STATUS` out 2: termination cause. 00 none, 01 halt, 10 hang, 11 timeout.
- `CYCLES` out CNT_W: RUN cycles in the current/last run.
- `RUN_COUNT` out 8: completed runs; saturates at 255.

## Operation

- States are IDLE, RESET, RUN, DONE. State encoding is free.
- Outputs by state:
  - IDLE: `CPU_RST`=1, `CPU_EN`=0, `DONE`=0.
  - RESET: `CPU_RST`=1, `CPU_EN`=0.
  - RUN: `CPU_RST`=0, `CPU_EN`=1.
  - DONE: `CPU_RST`=0, `CPU_EN`=0, `DONE`=1.
- IDLE → RESET on `START`. DONE → RESET on `START`.
- Entering RESET:
  - clears `CYCLES`, `STATUS`, the stall counter and `DONE`;
  - loads the reset counter with `RST_CYCLES`-1.
- RESET → RUN when the reset counter reaches 0.
- In RUN, `CYCLES` increments by 1 per cycle.
- Hang detection:
  - The stall counter increments when `PC_IN` equals the PC registered the previous cycle. Any change clears it.
  - Comparison is disabled on the first RUN cycle.
- RUN exit conditions, evaluated each RUN cycle, in priority order (ABORT beats all others):
  - `ABORT` → RESET. `RUN_COUNT` is unchanged and `STATUS` stays 00.
  - `INSTR_VALID` and `INSTR_IN` = 0x00000073 (ECALL) or 0x00100073 (EBREAK) → DONE, `STATUS`=01.
  - stall counter reaches `STALL_LIMIT`-1 and the PC is again unchanged → DONE, `STATUS`=10.
  - `CYCLES` = `MAX_CYCLES`-1 (this cycle would make it `MAX_CYCLES`) → DONE, `STATUS`=11.
- On any RUN → DONE transition, `RUN_COUNT` increments (saturating) and `CYCLES` includes the final RUN cycle.
- In DONE, `CYCLES`, `STATUS` and `RUN_COUNT` hold.
- Ignored inputs:
  - `START` in RESET or RUN.
  - `ABORT` outside RUN.
- `RST` overrides everything: next state IDLE. Reset values: `CPU_RST`=1, `CPU_EN`=0, `DONE`=0, `STATUS`=00, `CYCLES`=0, `RUN_COUNT`=0, all internal counters 0.
- `RST` mid-run also clears `RUN_COUNT`. `ABORT` does not.

## Timing

- All outputs are registered. None depends combinationally on inputs.
- `START` high at edge N (in IDLE/DONE): `CPU_RST`=1 from N+1 for exactly `RST_CYCLES` cycles. `CPU_EN`=1 from N+1+`RST_CYCLES`.
- An exit condition true at RUN edge M: `CPU_EN`=0 and `DONE`/`STATUS` valid from M+1. The M edge itself is counted in `CYCLES`.
- `ABORT` at RUN edge M: `CPU_RST`=1 from M+1. The full `RST_CYCLES` sequence replays.
- A halt on the first RUN cycle ends the run with `CYCLES`=1.
- `RST` asserted: all outputs take their reset values at the next edge, regardless of state.

## Test plan

Parameters for all scenarios: `RST_CYCLES`=2, `MAX_CYCLES`=20, `STALL_LIMIT`=4.

- **Reset defaults.** Pulse `RST`, then idle for 5 cycles → `CPU_RST`=1, `CPU_EN`=0, `DONE`=0, `STATUS`=00, `CYCLES`=0, `RUN_COUNT`=0 throughout.
- **Halt.** `START` 1 cycle → `CPU_RST` high exactly 2 cycles, then `CPU_EN`=1. Drive PC incrementing by 4 and present ECALL (0x00000073, valid) on RUN cycle 7 → next cycle `DONE`=1, `STATUS`=01, `CYCLES`=7, `RUN_COUNT`=1.
- **Hang.** Run with PC stuck at 0x40 from RUN cycle 3 onward → `STATUS`=10, `CYCLES`=6.
- **Timeout.** PC keeps incrementing, no ECALL → `STATUS`=11 and `CYCLES`=20, `CPU_EN` low on the following cycle.
- **Abort.** `ABORT` on RUN cycle 5 → `CPU_RST` high 2 cycles, `CYCLES` restarts from 0, `RUN_COUNT` unchanged. `START` in RUN is ignored.
- **Simultaneous events and re-run.**
  - EBREAK on the same cycle as the timeout → `STATUS`=01.
  - `START` from DONE starts a new run; `RUN_COUNT`=2 after it ends.
  - `RST` mid-run → IDLE with `RUN_COUNT`=0.

Source files
------------

// File: rtl/cpu_run_sequencer.sv
// Run controller for a CPU core: multi-cycle core reset, enabled run, self-termination on halt/hang/timeout.
// All outputs are registered. START and ABORT act one edge after sampling. There is no backpressure.
module cpu_run_sequencer #(
  parameter int RST_CYCLES  = 2,
  parameter int MAX_CYCLES  = 1000,
  parameter int STALL_LIMIT = 16,
  parameter int CNT_W       = 32,
  parameter int PC_W        = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic [PC_W-1:0]  PC_IN,
  input  logic [31:0]      INSTR_IN,
  input  logic             INSTR_VALID,
  output logic             CPU_RST,
  output logic             CPU_EN,
  output logic             DONE,
  output logic [1:0]       STATUS,
  output logic [CNT_W-1:0] CYCLES,
  output logic [7:0]       RUN_COUNT
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int SC_W = $clog2(STALL_LIMIT + 1);

  localparam logic [RC_W-1:0]  RST_LOAD   = RC_W'(RST_CYCLES - 1);
  localparam logic [SC_W-1:0]  STALL_LAST = SC_W'(STALL_LIMIT - 1);
  localparam logic [CNT_W-1:0] CYC_LAST   = CNT_W'(MAX_CYCLES - 1);

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [RC_W-1:0] rst_cnt;
  logic [SC_W-1:0] stall_cnt;
  logic [PC_W-1:0] prev_pc;

  logic first_run;
  logic pc_same;
  logic halt_hit;
  logic hang_hit;
  logic tmo_hit;
  logic go_reset;

  always_comb begin
    // The first RUN cycle has no valid previous PC to compare against.
    first_run = (CYCLES == '0);
    pc_same   = !first_run && (PC_IN == prev_pc);
    halt_hit  = INSTR_VALID && ((INSTR_IN == ECALL) || (INSTR_IN == EBREAK));
    hang_hit  = pc_same && (stall_cnt == STALL_LAST);
    tmo_hit   = (CYCLES == CYC_LAST);
    go_reset  = (((state == S_IDLE) || (state == S_DONE)) && START) ||
                ((state == S_RUN) && ABORT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      rst_cnt   <= '0;
      stall_cnt <= '0;
      prev_pc   <= '0;
      CPU_RST   <= 1'b1;
      CPU_EN    <= 1'b0;
      DONE      <= 1'b0;
      STATUS    <= 2'b00;
      CYCLES    <= '0;
      RUN_COUNT <= '0;
    end else begin
      case (state)
        S_RESET: begin
          if (rst_cnt == '0) begin
            state   <= S_RUN;
            CPU_RST <= 1'b0;
            CPU_EN  <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt - RC_W'(1);
          end
        end
        S_RUN: begin
          if (!ABORT) begin
            CYCLES    <= CYCLES + CNT_W'(1);
            prev_pc   <= PC_IN;
            stall_cnt <= pc_same ? stall_cnt + SC_W'(1) : '0;
            if (halt_hit || hang_hit || tmo_hit) begin
              state  <= S_DONE;
              CPU_EN <= 1'b0;
              DONE   <= 1'b1;
              STATUS <= halt_hit ? 2'b01 : (hang_hit ? 2'b10 : 2'b11);
              if (RUN_COUNT != 8'hFF) RUN_COUNT <= RUN_COUNT + 8'd1;
            end
          end
        end
        default: ;
      endcase

      // Start from IDLE/DONE and abort from RUN share the same reset-entry path.
      if (go_reset) begin
        state     <= S_RESET;
        rst_cnt   <= RST_LOAD;
        stall_cnt <= '0;
        CPU_RST   <= 1'b1;
        CPU_EN    <= 1'b0;
        DONE      <= 1'b0;
        STATUS    <= 2'b00;
        CYCLES    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Directed bench for cpu_run_sequencer with RST_CYCLES=2, MAX_CYCLES=20, STALL_LIMIT=4.
module tb_cpu_run_sequencer;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        ABORT;
  logic [31:0] PC_IN;
  logic [31:0] INSTR_IN;
  logic        INSTR_VALID;
  logic        CPU_RST;
  logic        CPU_EN;
  logic        DONE;
  logic [1:0]  STATUS;
  logic [31:0] CYCLES;
  logic [7:0]  RUN_COUNT;

  int n_cmp = 0;
  int n_bad = 0;

  cpu_run_sequencer #(
    .RST_CYCLES (2),
    .MAX_CYCLES (20),
    .STALL_LIMIT(4),
    .CNT_W      (32),
    .PC_W       (32)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (START),
    .ABORT      (ABORT),
    .PC_IN      (PC_IN),
    .INSTR_IN   (INSTR_IN),
    .INSTR_VALID(INSTR_VALID),
    .CPU_RST    (CPU_RST),
    .CPU_EN     (CPU_EN),
    .DONE       (DONE),
    .STATUS     (STATUS),
    .CYCLES     (CYCLES),
    .RUN_COUNT  (RUN_COUNT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start;
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  task automatic run_cyc(input logic [31:0] pc, input logic [31:0] ins, input logic v);
    PC_IN       = pc;
    INSTR_IN    = ins;
    INSTR_VALID = v;
    step();
  endtask

  task automatic test_reset;
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if ({CPU_RST, CPU_EN, DONE, STATUS} !== 5'b10000) begin
        n_bad++;
        $display("FAIL reset_ctrl[%0d]: got %b expected 10000", i, {CPU_RST, CPU_EN, DONE, STATUS});
      end
      n_cmp++;
      if ({CYCLES, RUN_COUNT} !== 40'd0) begin
        n_bad++;
        $display("FAIL reset_counts[%0d]: got cycles=%0d runs=%0d expected 0/0", i, CYCLES, RUN_COUNT);
      end
    end
  endtask

  task automatic test_halt;
    pulse_start();
    n_cmp++;
    if ({CPU_RST, CPU_EN, DONE} !== 3'b100) begin
      n_bad++;
      $display("FAIL halt_rst1: got %b expected 100", {CPU_RST, CPU_EN, DONE});
    end
    step();
    n_cmp++;
    if ({CPU_RST, CPU_EN, DONE} !== 3'b100) begin
      n_bad++;
      $display("FAIL halt_rst2: got %b expected 100", {CPU_RST, CPU_EN, DONE});
    end
    step();
    n_cmp++;
    if ({CPU_RST, CPU_EN, DONE} !== 3'b010) begin
      n_bad++;
      $display("FAIL halt_run_en: got %b expected 010", {CPU_RST, CPU_EN, DONE});
    end
    for (int k = 1; k <= 7; k++) begin
      run_cyc(32'(4 * (k - 1)), (k == 7) ? ECALL : NOP, 1'b1);
      if (k == 3) begin
        n_cmp++;
        if (CYCLES !== 32'd3) begin
          n_bad++;
          $display("FAIL halt_mid_cycles: got %0d expected 3", CYCLES);
        end
      end
    end
    INSTR_VALID = 1'b0;
    n_cmp++;
    if ({CPU_RST, CPU_EN, DONE, STATUS} !== 5'b00101) begin
      n_bad++;
      $display("FAIL halt_status: got %b expected 00101", {CPU_RST, CPU_EN, DONE, STATUS});
    end
    n_cmp++;
    if (CYCLES !== 32'd7) begin
      n_bad++;
      $display("FAIL halt_cycles: got %0d expected 7", CYCLES);
    end
    n_cmp++;
    if (RUN_COUNT !== 8'd1) begin
      n_bad++;
      $display("FAIL halt_runs: got %0d expected 1", RUN_COUNT);
    end
  endtask

  task automatic test_hang;
    pulse_start();
    step();
    step();
    run_cyc(32'h3c, NOP, 1'b1);
    for (int k = 2; k <= 6; k++) begin
      // An unqualified ECALL on cycle 2 must not halt the run.
      run_cyc(32'h40, (k == 2) ? ECALL : NOP, (k == 2) ? 1'b0 : 1'b1);
      if (k == 5) begin
        n_cmp++;
        if ({CPU_EN, DONE} !== 2'b10) begin
          n_bad++;
          $display("FAIL hang_early: got %b expected 10", {CPU_EN, DONE});
        end
      end
    end
    n_cmp++;
    if ({CPU_EN, DONE, STATUS} !== 4'b0110) begin
      n_bad++;
      $display("FAIL hang_status: got %b expected 0110", {CPU_EN, DONE, STATUS});
    end
    n_cmp++;
    if (CYCLES !== 32'd6) begin
      n_bad++;
      $display("FAIL hang_cycles: got %0d expected 6", CYCLES);
    end
    n_cmp++;
    if (RUN_COUNT !== 8'd2) begin
      n_bad++;
      $display("FAIL hang_runs: got %0d expected 2", RUN_COUNT);
    end
  endtask

  task automatic test_timeout;
    pulse_start();
    step();
    step();
    for (int k = 1; k <= 20; k++) begin
      run_cyc(32'h100 + 32'(4 * k), NOP, 1'b1);
      if (k == 19) begin
        n_cmp++;
        if ({CPU_EN, DONE, CYCLES} !== {2'b10, 32'd19}) begin
          n_bad++;
          $display("FAIL tmo_before: got en=%b done=%b cycles=%0d expected 1/0/19", CPU_EN, DONE, CYCLES);
        end
      end
    end
    n_cmp++;
    if ({CPU_RST, CPU_EN, DONE, STATUS} !== 5'b00111) begin
      n_bad++;
      $display("FAIL tmo_status: got %b expected 00111", {CPU_RST, CPU_EN, DONE, STATUS});
    end
    n_cmp++;
    if (CYCLES !== 32'd20) begin
      n_bad++;
      $display("FAIL tmo_cycles: got %0d expected 20", CYCLES);
    end
    n_cmp++;
    if (RUN_COUNT !== 8'd3) begin
      n_bad++;
      $display("FAIL tmo_runs: got %0d expected 3", RUN_COUNT);
    end
    // DONE holds its results and ignores ABORT.
    ABORT = 1'b1;
    step();
    step();
    ABORT = 1'b0;
    n_cmp++;
    if ({CPU_EN, DONE, STATUS, CYCLES, RUN_COUNT} !== {4'b0111, 32'd20, 8'd3}) begin
      n_bad++;
      $display("FAIL done_hold: got en=%b done=%b st=%b cyc=%0d runs=%0d expected 0/1/11/20/3",
               CPU_EN, DONE, STATUS, CYCLES, RUN_COUNT);
    end
  endtask

  task automatic test_abort;
    pulse_start();
    step();
    step();
    for (int k = 1; k <= 5; k++) begin
      ABORT = (k == 5);
      START = (k == 3);
      run_cyc(32'h200 + 32'(4 * k), NOP, 1'b1);
      START = 1'b0;
      if (k == 3) begin
        n_cmp++;
        if ({CPU_RST, CPU_EN, CYCLES} !== {2'b01, 32'd3}) begin
          n_bad++;
          $display("FAIL start_in_run: got rst=%b en=%b cyc=%0d expected 0/1/3", CPU_RST, CPU_EN, CYCLES);
        end
      end
    end
    ABORT = 1'b0;
    n_cmp++;
    if ({CPU_RST, CPU_EN, DONE, STATUS} !== 5'b10000) begin
      n_bad++;
      $display("FAIL abort_ctrl: got %b expected 10000", {CPU_RST, CPU_EN, DONE, STATUS});
    end
    n_cmp++;
    if ({CYCLES, RUN_COUNT} !== {32'd0, 8'd3}) begin
      n_bad++;
      $display("FAIL abort_counts: got cyc=%0d runs=%0d expected 0/3", CYCLES, RUN_COUNT);
    end
    step();
    n_cmp++;
    if ({CPU_RST, CPU_EN} !== 2'b10) begin
      n_bad++;
      $display("FAIL abort_rst2: got %b expected 10", {CPU_RST, CPU_EN});
    end
    step();
    n_cmp++;
    if ({CPU_RST, CPU_EN} !== 2'b01) begin
      n_bad++;
      $display("FAIL abort_rerun: got %b expected 01", {CPU_RST, CPU_EN});
    end
    run_cyc(32'h300, ECALL, 1'b1);
    INSTR_VALID = 1'b0;
    n_cmp++;
    if ({DONE, STATUS, CYCLES, RUN_COUNT} !== {3'b101, 32'd1, 8'd4}) begin
      n_bad++;
      $display("FAIL first_cycle_halt: got done=%b st=%b cyc=%0d runs=%0d expected 1/01/1/4",
               DONE, STATUS, CYCLES, RUN_COUNT);
    end
  endtask

  task automatic test_back_to_back;
    RST = 1'b1;
    step();
    RST = 1'b0;
    n_cmp++;
    if (RUN_COUNT !== 8'd0) begin
      n_bad++;
      $display("FAIL b2b_reset_runs: got %0d expected 0", RUN_COUNT);
    end
    pulse_start();
    step();
    step();
    for (int k = 1; k <= 20; k++)
      run_cyc(32'h400 + 32'(4 * k), (k == 20) ? EBREAK : NOP, 1'b1);
    INSTR_VALID = 1'b0;
    n_cmp++;
    if ({DONE, STATUS, CYCLES, RUN_COUNT} !== {3'b101, 32'd20, 8'd1}) begin
      n_bad++;
      $display("FAIL halt_vs_tmo: got done=%b st=%b cyc=%0d runs=%0d expected 1/01/20/1",
               DONE, STATUS, CYCLES, RUN_COUNT);
    end
    pulse_start();
    n_cmp++;
    if ({CPU_RST, CPU_EN, DONE, STATUS, CYCLES} !== {5'b10000, 32'd0}) begin
      n_bad++;
      $display("FAIL rerun_clear: got rst=%b en=%b done=%b st=%b cyc=%0d expected 1/0/0/00/0",
               CPU_RST, CPU_EN, DONE, STATUS, CYCLES);
    end
    step();
    step();
    run_cyc(32'h500, NOP, 1'b1);
    run_cyc(32'h504, ECALL, 1'b1);
    INSTR_VALID = 1'b0;
    n_cmp++;
    if ({DONE, STATUS, CYCLES, RUN_COUNT} !== {3'b101, 32'd2, 8'd2}) begin
      n_bad++;
      $display("FAIL rerun_done: got done=%b st=%b cyc=%0d runs=%0d expected 1/01/2/2",
               DONE, STATUS, CYCLES, RUN_COUNT);
    end
    pulse_start();
    step();
    step();
    for (int k = 1; k <= 3; k++)
      run_cyc(32'h600 + 32'(4 * k), NOP, 1'b1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    n_cmp++;
    if ({CPU_RST, CPU_EN, DONE, STATUS, CYCLES, RUN_COUNT} !== {5'b10000, 32'd0, 8'd0}) begin
      n_bad++;
      $display("FAIL rst_mid_run: got rst=%b en=%b done=%b st=%b cyc=%0d runs=%0d expected 1/0/0/00/0/0",
               CPU_RST, CPU_EN, DONE, STATUS, CYCLES, RUN_COUNT);
    end
    step();
    step();
    n_cmp++;
    if ({CPU_RST, CPU_EN, DONE} !== 3'b100) begin
      n_bad++;
      $display("FAIL idle_after_rst: got %b expected 100", {CPU_RST, CPU_EN, DONE});
    end
  endtask

  initial begin
    RST         = 1'b1;
    START       = 1'b0;
    ABORT       = 1'b0;
    PC_IN       = 32'h0;
    INSTR_IN    = NOP;
    INSTR_VALID = 1'b0;
    test_reset();
    test_halt();
    test_hang();
    test_timeout();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
